// File: rtl/divisor_sequencial_pkg.sv
// Purpose : shared definitions for the sequential restoring divider.
// Latency : n/a (types, constants and a helper function only).
// Backpr. : n/a.
//
// Contents: FSM state encoding and the quotient value reported on a
// divide-by-zero (all ones at the operand width).
package divisor_sequencial_pkg;

   typedef enum logic [1:0] {
      OCIOSO  = 2'b00,
      CALCULA = 2'b01,
      FIM     = 2'b10
   } estado_t;

   // All-ones quotient for a zero divisor, as a function of the operand
   // width. The caller truncates to its own width; valid for n <= 32.
   function automatic logic [31:0] div_zero_quoc(input int unsigned n);
      if (n >= 32) begin
         div_zero_quoc = 32'hFFFF_FFFF;
      end else begin
         div_zero_quoc = (32'd1 << n) - 32'd1;
      end
   endfunction

endpackage

// File: rtl/somador_subtrator.sv
// Purpose : combinational N-bit adder/subtractor with carry/borrow out.
// Latency : combinational, zero cycles.
// Backpr. : none, purely combinational.
//
// Ports:
//   a, b   : N-bit unsigned operands
//   select : 0 = a + b, 1 = a - b (two's complement, a + ~b + 1)
//   resul  : N+1-bit result; MSB is carry (add) or borrow/sign (subtract)
module somador_subtrator
   import divisor_sequencial_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         select,
   output logic [N:0]   resul
);

   logic [N:0] a_ext;
   logic [N:0] b_ext;

   // Operands are zero-extended first so that, when subtracting, the MSB
   // of the result is set exactly when b > a (borrow).
   assign a_ext = {1'b0, a};
   assign b_ext = {1'b0, b} ^ {(N + 1){select}};
   assign resul = a_ext + b_ext + {{N{1'b0}}, select};

endmodule

// File: rtl/divisor_sequencial.sv
// Purpose : unsigned restoring divider, one quotient bit per cycle.
// Latency : N+1 cycles from accepted start to pronto (1 cycle on /0).
// Backpr. : none; iniciar is only honoured while idle, never queued.
//
// Ports:
//   clock, reset         : rising-edge clock, synchronous active-low reset
//   iniciar              : start request, sampled only while idle
//   dividendo, divisor   : N-bit operands, captured when start is accepted
//   quociente, resto     : registered results, held until the next start
//   ocupado              : high while iterating
//   pronto               : one-cycle pulse, results valid
//   erro_div_zero        : set with pronto on a zero divisor, held until
//                          the next accepted start
module divisor_sequencial
   import divisor_sequencial_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         iniciar,
   input  logic [N-1:0] dividendo,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quociente,
   output logic [N-1:0] resto,
   output logic         ocupado,
   output logic         pronto,
   output logic         erro_div_zero
);

   localparam int CW = $clog2(N + 1);
   localparam logic [N-1:0] DIV_ZERO_QUOC = N'(div_zero_quoc(N));

   estado_t        estado_q, estado_d;
   logic [N-1:0]   q_q, q_d;            // dividend shifting out, quotient in
   logic [N-1:0]   d_q, d_d;            // captured divisor
   logic [N:0]     r_q, r_d;            // partial remainder
   logic [CW-1:0]  cnt_q, cnt_d;        // iterations still to do
   logic [N-1:0]   quociente_q, quociente_d;
   logic [N-1:0]   resto_q, resto_d;
   logic           ocupado_q, ocupado_d;
   logic           pronto_q, pronto_d;
   logic           erro_q, erro_d;

   logic [N:0]     shifted;
   logic [N:0]     divisor_ext;
   logic [N+1:0]   diff;
   logic           unused_r_msb;

   // The remainder after a restoring step is always below the divisor, so
   // its MSB only matters transiently inside the trial subtraction.
   assign unused_r_msb = r_q[N];

   assign shifted     = {r_q[N-1:0], q_q[N-1]};
   assign divisor_ext = {1'b0, d_q};

   somador_subtrator #(
      .N (N + 1)
   ) u_trial_sub (
      .a      (shifted),
      .b      (divisor_ext),
      .select (1'b1),
      .resul  (diff)
   );

   always_comb begin
      estado_d    = estado_q;
      q_d         = q_q;
      d_d         = d_q;
      r_d         = r_q;
      cnt_d       = cnt_q;
      quociente_d = quociente_q;
      resto_d     = resto_q;
      erro_d      = erro_q;

      case (estado_q)
         OCIOSO: begin
            if (iniciar) begin
               q_d    = dividendo;
               d_d    = divisor;
               r_d    = '0;
               cnt_d  = CW'(N);
               erro_d = 1'b0;
               if (divisor == '0) begin
                  // Skip iterating: report the saturated quotient and the
                  // untouched dividend as remainder right away.
                  estado_d    = FIM;
                  quociente_d = DIV_ZERO_QUOC;
                  resto_d     = dividendo;
                  erro_d      = 1'b1;
               end else begin
                  estado_d = CALCULA;
               end
            end
         end

         CALCULA: begin
            if (!diff[N+1]) begin
               r_d = diff[N:0];
               q_d = {q_q[N-2:0], 1'b1};
            end else begin
               r_d = shifted;
               q_d = {q_q[N-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            // On the last iteration publish the post-step values so the
            // outputs are already valid during the pronto cycle.
            if (cnt_q == CW'(1)) begin
               estado_d    = FIM;
               quociente_d = q_d;
               resto_d     = r_d[N-1:0];
            end
         end

         FIM: begin
            estado_d = OCIOSO;
         end

         default: begin
            estado_d = OCIOSO;
         end
      endcase

      ocupado_d = (estado_d == CALCULA);
      pronto_d  = (estado_d == FIM);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q    <= OCIOSO;
         q_q         <= '0;
         d_q         <= '0;
         r_q         <= '0;
         cnt_q       <= '0;
         quociente_q <= '0;
         resto_q     <= '0;
         ocupado_q   <= 1'b0;
         pronto_q    <= 1'b0;
         erro_q      <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         q_q         <= q_d;
         d_q         <= d_d;
         r_q         <= r_d;
         cnt_q       <= cnt_d;
         quociente_q <= quociente_d;
         resto_q     <= resto_d;
         ocupado_q   <= ocupado_d;
         pronto_q    <= pronto_d;
         erro_q      <= erro_d;
      end
   end

   assign quociente     = quociente_q;
   assign resto         = resto_q;
   assign ocupado       = ocupado_q;
   assign pronto        = pronto_q;
   assign erro_div_zero = erro_q;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Purpose : directed self-checking bench for divisor_sequencial (N = 8).
// Latency : checks ocupado window, pronto position and result values.
// Backpr. : drives iniciar idle, mid-division and held high.
module tb_divisor_sequencial;

   localparam int N = 8;

   logic         clock;
   logic         reset;
   logic         iniciar;
   logic [N-1:0] dividendo;
   logic [N-1:0] divisor;
   logic [N-1:0] quociente;
   logic [N-1:0] resto;
   logic         ocupado;
   logic         pronto;
   logic         erro_div_zero;

   int n_tests = 0;
   int n_fail  = 0;

   divisor_sequencial #(
      .N (N)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .iniciar       (iniciar),
      .dividendo     (dividendo),
      .divisor       (divisor),
      .quociente     (quociente),
      .resto         (resto),
      .ocupado       (ocupado),
      .pronto        (pronto),
      .erro_div_zero (erro_div_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Starts one division and watches N+3 cycles after the accepting edge.
   // poke > 0 raises iniciar with other operands for one cycle mid-run.
   task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er,
                          input logic ez, input int poke);
      int ocup_cnt;
      int pr_cycle;
      int pr_count;
      logic [N-1:0] q_at;
      logic [N-1:0] r_at;
      logic e_at;
      ocup_cnt = 0;
      pr_cycle = -1;
      pr_count = 0;
      q_at = '0;
      r_at = '0;
      e_at = 1'b0;
      @(negedge clock);
      iniciar   = 1'b1;
      dividendo = a;
      divisor   = b;
      @(posedge clock);
      #1;
      iniciar   = 1'b0;
      dividendo = N'($urandom);
      divisor   = N'($urandom);
      for (int c = 1; c <= N + 3; c++) begin
         @(negedge clock);
         if (ocupado) ocup_cnt++;
         if (pronto) begin
            pr_count++;
            if (pr_cycle < 0) begin
               pr_cycle = c;
               q_at = quociente;
               r_at = resto;
               e_at = erro_div_zero;
            end
         end
         if (poke > 0 && c == poke) begin
            iniciar   = 1'b1;
            dividendo = 8'd50;
            divisor   = 8'd3;
         end
         if (poke > 0 && c == poke + 1) iniciar = 1'b0;
      end
      chk({tag, ".ocupado_cycles"}, ocup_cnt, (b == '0) ? 0 : N);
      chk({tag, ".pronto_cycle"}, pr_cycle, (b == '0) ? 1 : N + 1);
      chk({tag, ".pronto_count"}, pr_count, 1);
      chk({tag, ".quociente"}, q_at, eq);
      chk({tag, ".resto"}, r_at, er);
      chk({tag, ".erro"}, e_at, ez);
      chk({tag, ".held"}, {quociente, resto, 7'd0, erro_div_zero}, {eq, er, 7'd0, ez});
   endtask

   initial begin : main
      int pr_seen;
      int pr_at [3];
      iniciar   = 1'b0;
      dividendo = '0;
      divisor   = '0;
      reset     = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset.outputs", {quociente, resto, 5'd0, ocupado, pronto, erro_div_zero}, 32'd0);
      reset = 1'b1;

      run_div("d100_7",  8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 0);
      run_div("d255_1",  8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 0);
      run_div("d5_9",    8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 0);
      run_div("d255_255",8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 0);
      run_div("d200_0",  8'd200, 8'd0,   8'd255, 8'd200, 1'b1, 0);
      run_div("d10_3",   8'd10,  8'd3,   8'd3,   8'd1,   1'b0, 0);
      run_div("poke",    8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 4);

      // iniciar held high: three back-to-back divisions
      @(negedge clock);
      iniciar   = 1'b1;
      dividendo = 8'd100;
      divisor   = 8'd7;
      pr_seen   = 0;
      for (int c = 0; c < 40 && pr_seen < 3; c++) begin
         @(negedge clock);
         if (pronto) begin
            pr_at[pr_seen] = c;
            pr_seen++;
         end
      end
      iniciar = 1'b0;
      chk("b2b.count", pr_seen, 3);
      if (pr_seen == 3) begin
         chk("b2b.gap1", pr_at[1] - pr_at[0], N + 2);
         chk("b2b.gap2", pr_at[2] - pr_at[1], N + 2);
      end
      chk("b2b.result", {quociente, resto}, {8'd14, 8'd2});
      repeat (3) @(negedge clock);

      // reset in the middle of a 200/3 division
      iniciar   = 1'b1;
      dividendo = 8'd200;
      divisor   = 8'd3;
      @(posedge clock);
      #1;
      iniciar = 1'b0;
      for (int c = 1; c <= 5; c++) @(negedge clock);
      chk("midrst.busy", ocupado, 1'b1);
      reset = 1'b0;
      @(negedge clock);
      chk("midrst.outputs", {quociente, resto, 5'd0, ocupado, pronto, erro_div_zero}, 32'd0);
      reset = 1'b1;
      run_div("d200_3", 8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/divisor_sequencial.md
Name: divisor_sequencial

Overview:
- Multi-cycle unsigned restoring divider (shift-and-subtract).
- Computes quociente = dividendo / divisor and resto = dividendo % divisor in N iterations.
- Reuses the team's combinational add/subtract unit for the trial subtraction.
- Serves game logic needing division (screen-coordinate scaling, velocity normalisation, wrap-around modulo) without a combinational divider on the critical path.

Parameters:
N, 8, operand/result width in bits (N >= 2)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset, sampled on rising edge of clock
iniciar  input  1  start request, sampled only in OCIOSO
dividendo  input  N  unsigned dividend, captured when start is accepted
divisor  input  N  unsigned divisor, captured when start is accepted
quociente  output  N  unsigned quotient, registered
resto  output  N  unsigned remainder, registered
ocupado  output  1  high while a division is in progress (CALCULA)
pronto  output  1  one-cycle pulse: results valid
erro_div_zero  output  1  high together with and after pronto when captured divisor was 0; cleared on next accepted start

Behaviour:
- Reset (reset == 0 at a rising edge):
  - state goes to OCIOSO;
  - quociente, resto, ocupado, pronto, erro_div_zero and internal registers go to 0.
  - Reset overrides everything, including mid-division; no partial result is kept.
- State OCIOSO:
  - iniciar == 1 at edge k means the start is accepted.
  - Latch dividendo into Q register, divisor into D register; clear R register (N+1 bits); load iteration counter with N; clear erro_div_zero.
  - If divisor != 0, go to CALCULA. If divisor == 0, go to FIM.
- State CALCULA (ocupado = 1), one iteration per cycle:
  - shifted = {R[N-1:0], Q[N-1]} (N+1 bits);
  - diff = shifted - {1'b0, D}, computed on N+2 bits;
  - if diff[N+1] == 0 (no borrow): R <= diff[N:0], Q <= {Q[N-2:0], 1};
  - else: R <= shifted, Q <= {Q[N-2:0], 0};
  - decrement the counter. After exactly N cycles in CALCULA, go to FIM.
- State FIM, one cycle:
  - pronto = 1;
  - quociente <= Q, resto <= R[N-1:0] (registered on entry so they are valid in the pronto cycle);
  - next state is OCIOSO.
- Divide by zero:
  - FIM is reached one cycle after the accepted start;
  - quociente = all ones (2^N-1), resto = captured dividendo, erro_div_zero = 1.
- Latency: start accepted at edge k.
  - Normal division: ocupado high for cycles k+1..k+N; pronto high during cycle k+N+1.
  - Divide by zero: pronto high during cycle k+1 and ocupado stays 0.
- Results and erro_div_zero hold their values in OCIOSO until the next accepted start.
- iniciar during CALCULA or FIM is ignored; it is not queued.
- iniciar held high continuously starts a new division on the first OCIOSO cycle after FIM, so back-to-back throughput is N+2 cycles.
- Operand inputs may change freely after acceptance without affecting the running division.
- States outside the enum return to OCIOSO on the next edge.

Decomposition:
- Shared package:
  - state encoding constants OCIOSO = 2'b00, CALCULA = 2'b01, FIM = 2'b10;
  - DIV_ZERO_QUOC = all ones (function of N).
- Sub-module: one instance of somador_subtrator with N = N+1 and select = 1 (subtract).
  - a = shifted, b = {1'b0, D}.
  - resul is the N+2-bit diff; its MSB is the borrow/sign test.
- Counter and FSM live in divisor_sequencial itself.

Test Plan:
- N=8, reset low 2 cycles then high, iniciar pulse, dividendo=100, divisor=7 -> ocupado high 8 cycles, pronto single pulse 9 cycles after the accepting edge, quociente=14, resto=2, erro_div_zero=0; values held afterwards.
- dividendo=255, divisor=1 -> quociente=255, resto=0. Then dividendo=5, divisor=9 -> quociente=0, resto=5. Then dividendo=255, divisor=255 -> quociente=1, resto=0.
- dividendo=200, divisor=0 -> pronto in the cycle after start, ocupado never high, quociente=255, resto=200, erro_div_zero=1. Next start with 10/3 -> erro_div_zero=0, quociente=3, resto=1.
- Start 100/7, change operands and pulse iniciar at cycle 4 of CALCULA -> still 14/2 at pronto, no second pronto. iniciar held high over 3 divisions -> pronto pulses exactly 10 cycles apart.
- reset=0 at cycle 5 of a 200/3 division -> next cycle all outputs 0, state OCIOSO; a fresh 200/3 start -> quociente=66, resto=2 with normal latency.
